// File: rtl/ps2_keyboard_if.sv
// Bundle between the PS/2 pins, the keyboard receiver and the keyboard word consumer.
// The receiver uses the slave view; the pin driver and word consumer use the master view.
interface ps2_keyboard_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] kb_out;
    logic        code_valid;
    logic        frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  kb_out,
        input  code_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output kb_out,
        output code_valid,
        output frame_err
    );
endinterface

// File: rtl/ps2_keyboard.sv
// PS/2 device-to-host frame receiver with scan-code set 2 make/break/extended tracking.
// Holds the currently pressed key as {7'b0, ext, code} on kb_out, or 0 when no key is held.
module ps2_keyboard #(
    parameter int FILTER_LEN = 4,
    parameter int TIMEOUT    = 50000
) (
    input  logic           clk,
    input  logic           reset,
    ps2_keyboard_if.slave  bus
);

    localparam int TO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    // Odd parity over the data byte plus the parity bit.
    function automatic logic frame_parity_ok(input logic [7:0] data, input logic parity);
        return ^{data, parity};
    endfunction

    logic [1:0]      ps2_clk_sync_r;
    logic [1:0]      ps2_data_sync_r;
    logic [3:0]      filt_cnt_r;
    logic            fclk_r;
    logic            strobe_r;
    state_t          state_r;
    logic [7:0]      shift_r;
    logic [2:0]      bit_cnt_r;
    logic            parity_r;
    logic [TO_W-1:0] to_cnt_r;
    logic            ext_r;
    logic            brk_r;
    logic [15:0]     kb_out_r;
    logic            code_valid_r;
    logic            frame_err_r;
    logic            clk_s;
    logic            data_s;
    logic [8:0]      key_s;

    assign clk_s  = ps2_clk_sync_r[1];
    assign data_s = ps2_data_sync_r[1];
    assign key_s  = {ext_r, shift_r};

    assign bus.kb_out     = kb_out_r;
    assign bus.code_valid = code_valid_r;
    assign bus.frame_err  = frame_err_r;

    // Synchronise the raw pins and debounce the PS/2 clock; strobe_r marks each filtered falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_clk_sync_r  <= 2'b11;
            ps2_data_sync_r <= 2'b11;
            filt_cnt_r      <= 4'd0;
            fclk_r          <= 1'b1;
            strobe_r        <= 1'b0;
        end else begin
            ps2_clk_sync_r  <= {ps2_clk_sync_r[0], bus.ps2_clk};
            ps2_data_sync_r <= {ps2_data_sync_r[0], bus.ps2_data};
            strobe_r        <= 1'b0;
            if (clk_s != fclk_r) begin
                // The FILTER_LEN-th consecutive differing sample commits the new level.
                if (filt_cnt_r == 4'(FILTER_LEN - 1)) begin
                    fclk_r     <= clk_s;
                    filt_cnt_r <= 4'd0;
                    strobe_r   <= fclk_r & ~clk_s;
                end else begin
                    filt_cnt_r <= filt_cnt_r + 4'd1;
                end
            end else begin
                filt_cnt_r <= 4'd0;
            end
        end
    end

    // Frame FSM, inactivity timeout and scan-code decoder with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            shift_r      <= 8'd0;
            bit_cnt_r    <= 3'd0;
            parity_r     <= 1'b0;
            to_cnt_r     <= {TO_W{1'b0}};
            ext_r        <= 1'b0;
            brk_r        <= 1'b0;
            kb_out_r     <= 16'd0;
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            code_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            if (strobe_r) begin
                to_cnt_r <= {TO_W{1'b0}};
                case (state_r)
                    ST_IDLE: begin
                        if (!data_s) begin
                            state_r   <= ST_DATA;
                            bit_cnt_r <= 3'd0;
                        end
                    end
                    ST_DATA: begin
                        shift_r   <= {data_s, shift_r[7:1]};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_r <= data_s;
                        state_r  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_r <= ST_IDLE;
                        if (data_s && frame_parity_ok(shift_r, parity_r)) begin
                            case (shift_r)
                                8'hE0: ext_r <= 1'b1;
                                8'hF0: brk_r <= 1'b1;
                                8'hE1: begin
                                end
                                default: begin
                                    code_valid_r <= 1'b1;
                                    ext_r        <= 1'b0;
                                    brk_r        <= 1'b0;
                                    if (!brk_r) begin
                                        kb_out_r <= {7'd0, key_s};
                                    end else if ((kb_out_r != 16'd0) && (kb_out_r[8:0] == key_s)) begin
                                        kb_out_r <= 16'd0;
                                    end
                                end
                            endcase
                        end else begin
                            frame_err_r <= 1'b1;
                            ext_r       <= 1'b0;
                            brk_r       <= 1'b0;
                        end
                    end
                    default: state_r <= ST_IDLE;
                endcase
            end else if (state_r != ST_IDLE) begin
                if (to_cnt_r == TO_W'(TIMEOUT)) begin
                    state_r     <= ST_IDLE;
                    to_cnt_r    <= {TO_W{1'b0}};
                    frame_err_r <= 1'b1;
                    ext_r       <= 1'b0;
                    brk_r       <= 1'b0;
                end else begin
                    to_cnt_r <= to_cnt_r + TO_W'(1);
                end
            end else begin
                to_cnt_r <= {TO_W{1'b0}};
            end
        end
    end

endmodule

// File: doc/ps2_keyboard.md
# ps2_keyboard

PS/2 keyboard receiver that drives the 16-bit keyboard word read by the data memory's keyboard port (`kb_in`). It deserialises PS/2 device-to-host frames and tracks scan-code set 2 make/break/extended sequences. It holds the code of the currently pressed key on `kb_out`, or 0 when no key is held. It sits between the board's PS/2 pins and `computer`'s `kb_in` input.

## Interface
- `FILTER_LEN`, default 4: number of consecutive equal synchronised `ps2_clk` samples required before the filtered clock level changes (range 2–15).
- `TIMEOUT`, default 50000: number of `clk` cycles without a filtered falling edge, while a frame is in progress, that aborts the frame (≥ 2).

Ports:
- `clk`, input, 1: system clock. All state changes on its rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `ps2_clk`, input, 1: raw PS/2 clock from the device; asynchronous; idles high.
- `ps2_data`, input, 1: raw PS/2 data from the device; asynchronous; idles high.
- `kb_out`, output, 16: held-key word, connected to `kb_in`. Value is 0 or `{7'b0, ext, code[7:0]}`.
- `code_valid`, output, 1: one-cycle pulse for each accepted non-prefix scan byte.
- `frame_err`, output, 1: one-cycle pulse for each parity, stop-bit or timeout error.

## Operation
- **Input conditioning**
  - `ps2_clk` and `ps2_data` each pass through a 2-FF synchroniser; both flops reset to 1.
  - Filtered clock `fclk` resets to 1. It takes the synchronised `ps2_clk` value only after `FILTER_LEN` consecutive equal samples.
  - A falling edge of `fclk` is the sample strobe. The synchronised `ps2_data` is sampled on that cycle.
- **Frame FSM**, states IDLE, DATA, PARITY, STOP. On each strobe:
  - IDLE: data=0 (start bit) goes to DATA with bit count 0. Data=1 is ignored: stay in IDLE, no error.
  - DATA: shift the bit in LSB-first. After the 8th bit, go to PARITY.
  - PARITY: store the bit and go to STOP.
  - STOP: the frame is good if data=1 and the count of ones in the 8 data bits plus the parity bit is odd. On a good frame, pass the byte to the decoder. On a bad frame, pulse `frame_err`, discard the byte and clear the prefix flags. Go to IDLE in either case.
  - Timeout: in any state except IDLE, a counter runs and resets to 0 on each strobe. When it reaches `TIMEOUT`, go to IDLE, pulse `frame_err` and clear the prefix flags.
- **Decoder** for a good byte `b`:
  - `b`=E0: set `ext`.
  - `b`=F0: set `brk`.
  - `b`=E1: ignore the byte; flags unchanged. Pause-key sequences are not specially decoded.
  - Any other byte: form `key = {ext, b}` and pulse `code_valid`. Then clear `ext` and `brk`.
    - If `brk`=0 (make): `kb_out <= {7'b0, key}`. A newer make replaces the held key; typematic repeats rewrite the same value.
    - If `brk`=1 and `key` equals `kb_out[8:0]` with `kb_out` nonzero: `kb_out <= 0`.
    - If `brk`=1 and `key` does not match: `kb_out` is unchanged.
- **Reset**, at any time including mid-frame:
  - `kb_out`=0, `code_valid`=0, `frame_err`=0.
  - FSM in IDLE; shift register, bit count, timeout counter, `ext` and `brk` cleared.
  - Synchronisers and `fclk` set to 1, so no strobe is generated on reset release.

## Timing
- Strobe latency: 2 synchroniser cycles + `FILTER_LEN` cycles after the raw `ps2_clk` falls.
- `kb_out` and `code_valid` update on the `clk` edge immediately after the STOP-bit strobe cycle. `frame_err` follows the same timing.
- `code_valid` and `frame_err` are high for exactly one cycle and are never high together.
- `kb_out` is registered, glitch-free, and changes only on those edges or on reset.
- A strobe in the same cycle the timeout counter reaches `TIMEOUT`: the strobe wins; the frame continues and the counter resets.
- Glitches on `ps2_clk` shorter than `FILTER_LEN` cycles produce no strobe.

## Test plan
- **Make code:** send frame 0x1C (parity 0, stop 1) → `kb_out`=0x001C one cycle after the stop strobe; `code_valid` pulses once; `frame_err` stays 0.
- **Break code:** then send F0, 1C → `kb_out`=0x0000; exactly one further `code_valid` pulse (none for F0).
- **Extended key:** send E0 75 → `kb_out`=0x0175. Then E0 F0 75 → 0x0000. Then make 1C, make 32, break 1C → `kb_out` stays 0x0032.
- **Parity error:** send 0x1C with parity bit 1 while `kb_out`=0x0032 → one `frame_err` pulse; `kb_out` unchanged. Next, send an F0 frame with stop bit 0, then a valid 32 → the stop-bit error pulses `frame_err` and clears `brk`, so `kb_out` stays 0x0032 (treated as make, not break).
- **Timeout and glitch:** stop clocking after 4 data bits for `TIMEOUT` cycles → `frame_err` pulses; FSM in IDLE; a following valid 0x1C decodes to 0x001C. Then a `ps2_clk` low glitch of `FILTER_LEN`-1 cycles → no strobe, no state change.
- **Reset mid-operation:** hold key 0x1C, start a new frame, assert `reset` for 1 cycle after 3 bits → `kb_out`=0 immediately (asynchronous). The remaining bits of the frame produce no `code_valid`; a fresh 0x1C frame then gives `kb_out`=0x001C.
